multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Multicycle ARMv4 controller; successor to the single-cycle control unit.
- One FSM sequences fetch/decode/execute/memory/writeback over several cycles.
- Owns the NZCV flag register and the condition check.
- Adds a memory wait-state handshake and an optional extended ALU command set.
- Drives the shared-memory multicycle datapath: PC, IR, ALU muxes, register file, data memory.

Parameters:
- ALUC_W, 2: ALUControl width. 3 enables EOR/CMP decode.
- WAIT_EN, 1: 1 honours MemReady. 0 treats MemReady as constant 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low.
- Op  in  2  instr[27:26].
- Funct  in  6  instr[25:20].
- Rd  in  4  instr[15:12].
- Cond  in  4  instr[31:28].
- ALUFlags  in  4  N,Z,C,V from ALU.
- MemReady  in  1  memory access completes this cycle.
- PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA  out  1 each.
- ALUSrcB, ResultSrc, ImmSrc, RegSrc  out  2 each.
- ALUControl  out  ALUC_W.
- Flags  out  4  registered NZCV.
- Undef  out  1  one-cycle pulse on Op=11.

Behaviour:
- Reset asserted (low): state=FETCH, Flags=0000. PCWrite, IRWrite, RegWrite, MemWrite and Undef forced 0. Other outputs take their FETCH values.
- Reset mid-operation aborts immediately; no partial writes.
- Memory waits: FETCH, MEMREAD and MEMWRITE hold state while MemReady=0.
  - IRWrite and the NextPC PCWrite assert only in the FETCH cycle with MemReady=1.
  - MemWrite stays asserted through all MEMWRITE wait cycles.
- FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALU add, ResultSrc=10, IRWrite, PCWrite. Next: DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10. Next by Op:
  - 01 -> MEMADR.
  - 00 with Funct[5]=0 -> EXECUTER.
  - 00 with Funct[5]=1 -> EXECUTEI.
  - 10 -> BRANCH.
  - 11 -> FETCH, with Undef=1 for that cycle.
- MEMADR: ALUSrcA=0, ALUSrcB=01, add. Next: MEMREAD if Funct[0]=1, else MEMWRITE.
- MEMREAD: AdrSrc=1. Next: MEMWB.
- MEMWB: ResultSrc=01, RegWrite. Next: FETCH.
- MEMWRITE: AdrSrc=1, MemWrite. Next: FETCH.
- EXECUTER: ALUSrcA=0, ALUSrcB=00, ALU op from Funct[4:1]. Next: ALUWB.
- EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALU op from Funct[4:1]. Next: ALUWB.
- ALUWB: ResultSrc=00, RegWrite. Next: FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, PCWrite. Next: FETCH.
- ALU decode of Funct[4:1]:
  - 0100 ADD=0, 0010 SUB=1, 0000 AND=2, 1100 ORR=3.
  - ALUC_W=3 adds 0001 EOR=4 and 1010 CMP=SUB.
  - CMP never writes a register, even if S=0.
  - Any other command decodes as ADD with RegWrite suppressed.
- FlagW is gated by S=Funct[0]:
  - ADD/SUB/CMP: FlagW=11.
  - Logic ops: FlagW=10.
- Flag update at the end of an EXECUTE cycle, only when CondEx:
  - FlagW[1] loads N,Z from ALUFlags.
  - FlagW[0] loads C,V from ALUFlags.
- CondEx: combinational ARM condition over Cond and the current Flags. Codes 0000..1110 per ARM; 1111 gives CondEx=0.
- When CondEx=0:
  - RegWrite, MemWrite and branch/Rd=15 PCWrite are suppressed.
  - MEMWRITE exits to FETCH without waiting.
  - FETCH writes are never gated.
- Rd=15 with RegWrite in ALUWB or MEMWB: PCWrite=CondEx, RegWrite=0.
- Decoded ImmSrc:
  - data processing: 00.
  - memory: 01.
  - branch: 10.
- Decoded RegSrc:
  - RegSrc[0]=1 for branch.
  - RegSrc[1]=1 for STR.

Decomposition:
- Package arm_ctrl_pkg holds:
  - the state enum (10 states);
  - ALU op constants;
  - condition-code constants;
  - Op-field constants.
- Sub-module cond_check (combinational Cond, Flags -> CondEx), instantiated once.

Test Plan:
- ADD R1,R2,R3, always, MemReady=1:
  - required sequence: FETCH, DECODE, EXECUTER, ALUWB.
  - RegWrite=1 only in cycle 4.
  - ALUControl=0.
  - Instruction takes 4 cycles.
- LDR with MemReady low 2 cycles in FETCH and 3 in MEMREAD:
  - IRWrite pulses exactly once.
  - MemWB RegWrite follows after 5+5 cycles total.
- SUBS with ALUFlags=0100 then BEQ:
  - Flags=0100 after execute.
  - BRANCH asserts PCWrite.
- BNE in the same case: no PCWrite.
- STRNE with Z=1:
  - MemWrite=0.
  - MEMWRITE exits the next cycle regardless of MemReady.
- reset driven low during the second MEMWRITE wait cycle:
  - MemWrite drops asynchronously.
  - state=FETCH, Flags=0000.
- Op=11:
  - Undef=1 for one cycle in DECODE, then FETCH.
- ALUC_W=3, EORS:
  - ALUControl=4, FlagW=10.
  - C and V unchanged.

Source files
------------

// File: rtl/arm_ctrl_pkg.sv
// Shared types and constants for the multicycle ARMv4 controller:
// FSM states, instruction field encodings, ALU selects and condition codes.
package arm_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECUTER,
    EXECUTEI,
    ALUWB,
    BRANCH
  } state_t;

  // instr[27:26]
  localparam logic [1:0] OP_DP    = 2'b00;
  localparam logic [1:0] OP_MEM   = 2'b01;
  localparam logic [1:0] OP_BR    = 2'b10;
  localparam logic [1:0] OP_UNDEF = 2'b11;

  // ALUControl encodings (EOR only reachable with a 3-bit ALUControl)
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_ORR = 3'd3;
  localparam logic [2:0] ALU_EOR = 3'd4;

  // Data-processing cmd field, instr[24:21]
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // ARM condition field, instr[31:28]
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  // Result of decoding a data-processing command
  typedef struct packed {
    logic [2:0] alu_op;  // ALU select
    logic [1:0] flag_w;  // [1]: load N,Z  [0]: load C,V
    logic       no_wb;   // suppress the register write-back
  } alu_dec_t;

  // Decode cmd/S into ALU select, flag-write enables and write-back suppression.
  // Unknown commands fall back to ADD with no write-back and no flag update.
  function automatic alu_dec_t alu_decode(input logic [3:0] cmd,
                                          input logic       s,
                                          input logic       ext_en);
    alu_dec_t d;
    d.alu_op = ALU_ADD;
    d.flag_w = 2'b00;
    d.no_wb  = 1'b0;
    case (cmd)
      CMD_ADD: d.flag_w = {s, s};
      CMD_SUB: begin
        d.alu_op = ALU_SUB;
        d.flag_w = {s, s};
      end
      CMD_AND: begin
        d.alu_op = ALU_AND;
        d.flag_w = {s, 1'b0};
      end
      CMD_ORR: begin
        d.alu_op = ALU_ORR;
        d.flag_w = {s, 1'b0};
      end
      CMD_EOR: begin
        if (ext_en) begin
          d.alu_op = ALU_EOR;
          d.flag_w = {s, 1'b0};
        end else begin
          d.no_wb = 1'b1;
        end
      end
      CMD_CMP: begin
        // CMP is a flag-only SUB: it never writes a register
        d.no_wb = 1'b1;
        if (ext_en) begin
          d.alu_op = ALU_SUB;
          d.flag_w = {s, s};
        end
      end
      default: d.no_wb = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cond_check.sv
// ARM condition evaluation: Cond field against the registered NZCV flags.
module cond_check
  import arm_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  // Standard ARM condition table; the NV slot never executes
  always_comb begin
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      COND_NV: cond_ex = 1'b0;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle ARMv4 controller: one FSM sequences fetch/decode/execute/
// memory/writeback, owns the NZCV register and gates writes on the condition.
module multicycle_control_unit
  import arm_ctrl_pkg::*;
#(
  parameter int ALUC_W  = 2,     // 3 enables EOR / CMP decode
  parameter bit WAIT_EN = 1'b1   // 0 ignores MemReady
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        Op,
  input  logic [5:0]        Funct,
  input  logic [3:0]        Rd,
  input  logic [3:0]        Cond,
  input  logic [3:0]        ALUFlags,
  input  logic              MemReady,
  output logic              PCWrite,
  output logic              IRWrite,
  output logic              RegWrite,
  output logic              MemWrite,
  output logic              AdrSrc,
  output logic              ALUSrcA,
  output logic [1:0]        ALUSrcB,
  output logic [1:0]        ResultSrc,
  output logic [1:0]        ImmSrc,
  output logic [1:0]        RegSrc,
  output logic [ALUC_W-1:0] ALUControl,
  output logic [3:0]        Flags,
  output logic              Undef
);

  localparam bit EXT_EN = (ALUC_W >= 3);

  state_t     state, state_next;
  logic [3:0] flags_q;
  logic       cond_ex;
  logic       ready;
  logic       is_exec;
  alu_dec_t   dec;
  logic [2:0] alu_sel;
  logic       pc_write, ir_write, reg_write, mem_write, undef;
  logic       wb_req;

  assign ready   = WAIT_EN ? MemReady : 1'b1;
  assign is_exec = (state == EXECUTER) || (state == EXECUTEI);
  assign dec     = alu_decode(Funct[4:1], Funct[0], EXT_EN);

  cond_check u_cond_check (
    .cond    (Cond),
    .flags   (flags_q),
    .cond_ex (cond_ex)
  );

  // State register; reset aborts any sequence and returns to FETCH
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= state_next;
  end

  // NZCV register, loaded at the end of a taken execute cycle per flag-write enables
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= 4'b0000;
    end else if (is_exec && cond_ex) begin
      if (dec.flag_w[1]) flags_q[3:2] <= ALUFlags[3:2];
      if (dec.flag_w[0]) flags_q[1:0] <= ALUFlags[1:0];
    end
  end

  // Next-state and per-state datapath controls
  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    undef      = 1'b0;
    wb_req     = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    alu_sel    = ALU_ADD;

    case (state)
      FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (Op)
          OP_MEM:   state_next = MEMADR;
          OP_DP:    state_next = Funct[5] ? EXECUTEI : EXECUTER;
          OP_BR:    state_next = BRANCH;
          OP_UNDEF: begin
            undef      = 1'b1;
            state_next = FETCH;
          end
          default:  state_next = FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcB    = 2'b01;
        state_next = Funct[0] ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        if (ready) state_next = MEMWB;
      end
      MEMWB: begin
        ResultSrc  = 2'b01;
        wb_req     = 1'b1;
        state_next = FETCH;
      end
      MEMWRITE: begin
        // A failed condition has nothing to wait for, so leave immediately
        AdrSrc    = 1'b1;
        mem_write = cond_ex;
        if (ready || !cond_ex) state_next = FETCH;
      end
      EXECUTER: begin
        alu_sel    = dec.alu_op;
        state_next = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcB    = 2'b01;
        alu_sel    = dec.alu_op;
        state_next = ALUWB;
      end
      ALUWB: begin
        wb_req     = ~dec.no_wb;
        state_next = FETCH;
      end
      BRANCH: begin
        ALUSrcB    = 2'b01;
        ResultSrc  = 2'b10;
        pc_write   = cond_ex;
        state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
  end

  // Write-back steering: a write to R15 becomes a PC write instead
  always_comb begin
    reg_write = 1'b0;
    if (wb_req) begin
      if (Rd == 4'd15) reg_write = 1'b0;
      else             reg_write = cond_ex;
    end
  end

  // Immediate and register-source selects depend only on the instruction class
  always_comb begin
    ImmSrc = 2'b00;
    RegSrc = 2'b00;
    case (Op)
      OP_MEM: begin
        ImmSrc    = 2'b01;
        RegSrc[1] = ~Funct[0];  // STR reads Rd as the store data
      end
      OP_BR: begin
        ImmSrc    = 2'b10;
        RegSrc[0] = 1'b1;
      end
      default: ;
    endcase
  end

  // Write strobes are forced low for as long as reset is held
  assign PCWrite    = reset & (pc_write | (wb_req & (Rd == 4'd15) & cond_ex));
  assign IRWrite    = reset & ir_write;
  assign RegWrite   = reset & reg_write;
  assign MemWrite   = reset & mem_write;
  assign Undef      = reset & undef;
  assign ALUControl = ALUC_W'(alu_sel);
  assign Flags      = flags_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit (ALUC_W=3, WAIT_EN=1).
// Each instruction is expanded into its expected state sequence and checked
// cycle by cycle against outputs derived from the instruction class.
module tb_multicycle_control_unit;
  import arm_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] Op = 2'b00;
  logic [5:0] Funct = 6'd0;
  logic [3:0] Rd = 4'd0;
  logic [3:0] Cond = 4'hE;
  logic [3:0] ALUFlags = 4'd0;
  logic       MemReady = 1'b0;
  logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, Undef;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc;
  logic [2:0] ALUControl;
  logic [3:0] Flags;

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] m_flags = 4'b0000;

  typedef struct packed {
    state_t ph;
    logic   rdy;
  } beat_t;
  beat_t plan[$];

  multicycle_control_unit #(.ALUC_W(3), .WAIT_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .Cond(Cond),
    .ALUFlags(ALUFlags), .MemReady(MemReady), .PCWrite(PCWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
    .ALUControl(ALUControl), .Flags(Flags), .Undef(Undef)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ARM condition: pairs of codes share a base test, odd code inverts it
  function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    {n, z, cf, v} = f;
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cf;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cf && !z;
      3'd5:    base = (n == v);
      3'd6:    base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'b1111) return 1'b0;
    if (c == 4'b1110) return 1'b1;
    return base ^ c[0];
  endfunction

  // Command table for the 3-bit ALUControl build
  function automatic void dp_decode(input logic [3:0] cmd, input logic s,
                                    output logic [2:0] aop, output logic [1:0] fw,
                                    output logic wr);
    case (cmd)
      4'b0100: begin aop = 3'd0; fw = {s, s};    wr = 1'b1; end
      4'b0010: begin aop = 3'd1; fw = {s, s};    wr = 1'b1; end
      4'b0000: begin aop = 3'd2; fw = {s, 1'b0}; wr = 1'b1; end
      4'b1100: begin aop = 3'd3; fw = {s, 1'b0}; wr = 1'b1; end
      4'b0001: begin aop = 3'd4; fw = {s, 1'b0}; wr = 1'b1; end
      4'b1010: begin aop = 3'd1; fw = {s, s};    wr = 1'b0; end
      default: begin aop = 3'd0; fw = 2'b00;     wr = 1'b0; end
    endcase
  endfunction

  task automatic add_beat(input state_t p, input logic r);
    beat_t b;
    b.ph  = p;
    b.rdy = r;
    plan.push_back(b);
  endtask

  // Run one instruction; stops early (before the edge) after beat abort_at
  task automatic run_instr(input logic [1:0] op, input logic [5:0] funct,
                           input logic [3:0] rd, input logic [3:0] cond,
                           input logic [3:0] af, input int wf, input int wm,
                           input int abort_at,
                           output int ncyc, output int n_irw, output int n_pcw,
                           output int n_rw, output int n_mw, output int n_und,
                           output int rw_at);
    logic [2:0]  aop;
    logic [1:0]  fw;
    logic        dpwr, ce, ce0, wb;
    logic        e_pcw, e_irw, e_rw, e_mw, e_und, e_adr, e_a;
    logic [1:0]  e_b, e_res, e_imm, e_reg;
    logic [2:0]  e_alu;
    logic        k_adr, k_a, k_b, k_res, k_alu;
    logic [13:0] act, exp_v, msk;
    state_t      ph;

    ncyc = 0; n_irw = 0; n_pcw = 0; n_rw = 0; n_mw = 0; n_und = 0; rw_at = -1;
    dp_decode(funct[4:1], funct[0], aop, fw, dpwr);
    ce0 = cond_holds(cond, m_flags);

    plan.delete();
    for (int i = 0; i < wf; i++) add_beat(FETCH, 1'b0);
    add_beat(FETCH, 1'b1);
    add_beat(DECODE, 1'($urandom));
    case (op)
      2'b00: begin
        add_beat(funct[5] ? EXECUTEI : EXECUTER, 1'($urandom));
        add_beat(ALUWB, 1'($urandom));
      end
      2'b01: begin
        add_beat(MEMADR, 1'($urandom));
        if (funct[0]) begin
          for (int i = 0; i < wm; i++) add_beat(MEMREAD, 1'b0);
          add_beat(MEMREAD, 1'b1);
          add_beat(MEMWB, 1'($urandom));
        end else if (ce0) begin
          for (int i = 0; i < wm; i++) add_beat(MEMWRITE, 1'b0);
          add_beat(MEMWRITE, 1'b1);
        end else begin
          add_beat(MEMWRITE, 1'b0);
        end
      end
      2'b10: add_beat(BRANCH, 1'($urandom));
      default: ;
    endcase

    e_imm = (op == 2'b01) ? 2'b01 : (op == 2'b10) ? 2'b10 : 2'b00;
    e_reg = {(op == 2'b01) && !funct[0], op == 2'b10};

    for (int k = 0; k < plan.size(); k++) begin
      @(negedge clk);
      Op = op; Funct = funct; Rd = rd; Cond = cond; ALUFlags = af;
      MemReady = plan[k].rdy;
      #1;
      ph = plan[k].ph;
      ce = cond_holds(cond, m_flags);
      e_pcw = 0; e_irw = 0; e_rw = 0; e_mw = 0; e_und = 0; wb = 0;
      e_adr = 0; e_a = 0; e_b = 2'b00; e_res = 2'b00; e_alu = 3'd0;
      k_adr = 0; k_a = 0; k_b = 0; k_res = 0; k_alu = 0;
      case (ph)
        FETCH: begin
          e_pcw = plan[k].rdy; e_irw = plan[k].rdy;
          k_adr = 1; e_a = 1; k_a = 1; e_b = 2'b10; k_b = 1;
          e_res = 2'b10; k_res = 1; k_alu = 1;
        end
        DECODE: begin
          e_und = (op == 2'b11);
          e_a = 1; k_a = 1; e_b = 2'b10; k_b = 1; e_res = 2'b10; k_res = 1;
        end
        MEMADR: begin
          k_a = 1; e_b = 2'b01; k_b = 1; k_alu = 1;
        end
        MEMREAD:  begin e_adr = 1; k_adr = 1; end
        MEMWB:    begin e_res = 2'b01; k_res = 1; wb = 1; end
        MEMWRITE: begin e_adr = 1; k_adr = 1; e_mw = ce; end
        EXECUTER, EXECUTEI: begin
          k_a = 1; e_b = (ph == EXECUTEI) ? 2'b01 : 2'b00; k_b = 1;
          e_alu = aop; k_alu = 1;
        end
        ALUWB: begin k_res = 1; wb = dpwr; end
        BRANCH: begin
          k_a = 1; e_b = 2'b01; k_b = 1; e_res = 2'b10; k_res = 1; e_pcw = ce;
        end
        default: ;
      endcase
      if (wb) begin
        if (rd == 4'd15) e_pcw = ce;
        else             e_rw  = ce;
      end

      act   = {PCWrite, IRWrite, RegWrite, MemWrite, Undef, AdrSrc, ALUSrcA,
               ALUSrcB, ResultSrc, ALUControl};
      exp_v = {e_pcw, e_irw, e_rw, e_mw, e_und, e_adr, e_a, e_b, e_res, e_alu};
      msk   = {5'b11111, k_adr, k_a, {2{k_b}}, {2{k_res}}, {3{k_alu}}};
      n_cmp++;
      if (((act ^ exp_v) & msk) !== 14'd0) begin
        n_bad++;
        $display("FAIL ctl %s beat%0d: got %b want %b (care %b) op=%b funct=%b rd=%0d cond=%h",
                 ph.name(), k, act, exp_v, msk, op, funct, rd, cond);
      end
      n_cmp++;
      if (dut.state !== ph) begin
        n_bad++;
        $display("FAIL state beat%0d: got %0d want %s", k, dut.state, ph.name());
      end
      n_cmp++;
      if (Flags !== m_flags) begin
        n_bad++;
        $display("FAIL flags %s beat%0d: got %b want %b", ph.name(), k, Flags, m_flags);
      end
      n_cmp++;
      if ({ImmSrc, RegSrc} !== {e_imm, e_reg}) begin
        n_bad++;
        $display("FAIL immreg beat%0d: got %b want %b", k, {ImmSrc, RegSrc}, {e_imm, e_reg});
      end

      ncyc++;
      n_irw += int'(IRWrite);
      n_pcw += int'(PCWrite);
      n_rw  += int'(RegWrite);
      n_mw  += int'(MemWrite);
      n_und += int'(Undef);
      if (RegWrite === 1'b1) rw_at = k;

      if ((ph == EXECUTER || ph == EXECUTEI) && ce) begin
        if (fw[1]) m_flags[3:2] = af[3:2];
        if (fw[0]) m_flags[1:0] = af[1:0];
      end
      if (k == abort_at) break;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b0; MemReady = 1'b1; Op = 2'b11;
    #1;
    n_cmp++;
    if ({PCWrite, IRWrite, RegWrite, MemWrite, Undef} !== 5'b00000) begin
      n_bad++;
      $display("FAIL reset_strobes: got %b want 00000",
               {PCWrite, IRWrite, RegWrite, MemWrite, Undef});
    end
    n_cmp++;
    if (Flags !== 4'b0000 || dut.state !== FETCH) begin
      n_bad++;
      $display("FAIL reset_state: flags %b state %0d want 0000 FETCH", Flags, dut.state);
    end
    n_cmp++;
    if ({AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl} !== {1'b0, 1'b1, 2'b10, 2'b10, 3'd0}) begin
      n_bad++;
      $display("FAIL reset_mux: got %b want 01101 0000",
               {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl});
    end
    MemReady = 1'b0;
    reset = 1'b1;
    m_flags = 4'b0000;
  endtask

  task automatic test_add;
    int nc, ni, np, nr, nm, nu, ra;
    run_instr(2'b00, 6'b001000, 4'd1, 4'hE, 4'b0000, 0, 0, -1, nc, ni, np, nr, nm, nu, ra);
    n_cmp++;
    if (nc != 4 || nr != 1 || ra != 3) begin
      n_bad++;
      $display("FAIL add_timing: cycles %0d regwrites %0d at %0d want 4 1 3", nc, nr, ra);
    end
  endtask

  task automatic test_ldr_waits;
    int nc, ni, np, nr, nm, nu, ra;
    run_instr(2'b01, 6'b011001, 4'd4, 4'hE, 4'b0000, 2, 3, -1, nc, ni, np, nr, nm, nu, ra);
    n_cmp++;
    if (ni != 1 || nc != 10 || ra != 9) begin
      n_bad++;
      $display("FAIL ldr_waits: irwrites %0d cycles %0d regwrite at %0d want 1 10 9", ni, nc, ra);
    end
  endtask

  task automatic test_flags_branch;
    int nc, ni, np, nr, nm, nu, ra;
    run_instr(2'b00, 6'b000101, 4'd2, 4'hE, 4'b0100, 0, 0, -1, nc, ni, np, nr, nm, nu, ra);
    n_cmp++;
    if (Flags !== 4'b0100) begin
      n_bad++;
      $display("FAIL subs_flags: got %b want 0100", Flags);
    end
    run_instr(2'b10, 6'($urandom), 4'd0, 4'h0, 4'b0000, 1, 0, -1, nc, ni, np, nr, nm, nu, ra);
    n_cmp++;
    if (np != 2) begin
      n_bad++;
      $display("FAIL beq_taken: pcwrites %0d want 2", np);
    end
    run_instr(2'b10, 6'($urandom), 4'd0, 4'h1, 4'b0000, 0, 0, -1, nc, ni, np, nr, nm, nu, ra);
    n_cmp++;
    if (np != 1) begin
      n_bad++;
      $display("FAIL bne_not_taken: pcwrites %0d want 1", np);
    end
  endtask

  task automatic test_strne;
    int nc, ni, np, nr, nm, nu, ra;
    run_instr(2'b01, 6'b011000, 4'd3, 4'h1, 4'b0000, 0, 4, -1, nc, ni, np, nr, nm, nu, ra);
    n_cmp++;
    if (nm != 0 || nc != 4) begin
      n_bad++;
      $display("FAIL strne_skip: memwrites %0d cycles %0d want 0 4", nm, nc);
    end
  endtask

  task automatic test_reset_midop;
    int nc, ni, np, nr, nm, nu, ra;
    run_instr(2'b00, 6'b000101, 4'd2, 4'hE, 4'b1010, 0, 0, -1, nc, ni, np, nr, nm, nu, ra);
    // beats: FETCH, DECODE, MEMADR, MEMWRITE wait, MEMWRITE wait (index 4)
    run_instr(2'b01, 6'b011000, 4'd5, 4'hE, 4'b0000, 0, 3, 4, nc, ni, np, nr, nm, nu, ra);
    reset = 1'b0;
    #1;
    n_cmp++;
    if (MemWrite !== 1'b0 || PCWrite !== 1'b0 || RegWrite !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_strobes: memwrite %b pcwrite %b regwrite %b want 0 0 0",
               MemWrite, PCWrite, RegWrite);
    end
    n_cmp++;
    if (dut.state !== FETCH || Flags !== 4'b0000) begin
      n_bad++;
      $display("FAIL abort_state: state %0d flags %b want FETCH 0000", dut.state, Flags);
    end
    m_flags = 4'b0000;
    @(posedge clk);
    #1;
    n_cmp++;
    if (dut.state !== FETCH || MemWrite !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_hold: state %0d memwrite %b want FETCH 0", dut.state, MemWrite);
    end
    @(negedge clk);
    MemReady = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_undef;
    int nc, ni, np, nr, nm, nu, ra;
    run_instr(2'b11, 6'($urandom), 4'd0, 4'hE, 4'b0000, 1, 0, -1, nc, ni, np, nr, nm, nu, ra);
    n_cmp++;
    if (nu != 1 || nc != 3) begin
      n_bad++;
      $display("FAIL undef_pulse: pulses %0d cycles %0d want 1 3", nu, nc);
    end
  endtask

  task automatic test_eors;
    int nc, ni, np, nr, nm, nu, ra;
    run_instr(2'b00, 6'b001001, 4'd6, 4'hE, 4'b0011, 0, 0, -1, nc, ni, np, nr, nm, nu, ra);
    run_instr(2'b00, 6'b000011, 4'd7, 4'hE, 4'b1000, 0, 0, -1, nc, ni, np, nr, nm, nu, ra);
    n_cmp++;
    if (Flags !== 4'b1011) begin
      n_bad++;
      $display("FAIL eors_flags: got %b want 1011", Flags);
    end
  endtask

  function automatic logic [3:0] pick_cmd();
    case ($urandom_range(0, 5))
      0:       return 4'b0100;
      1:       return 4'b0010;
      2:       return 4'b0000;
      3:       return 4'b1100;
      4:       return 4'b0001;
      default: return 4'b1010;
    endcase
  endfunction

  task automatic test_random(input int count);
    int nc, ni, np, nr, nm, nu, ra;
    int sel;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd, cond;
    for (int i = 0; i < count; i++) begin
      sel = int'($urandom_range(0, 9));
      op = (sel < 4) ? 2'b00 : (sel < 7) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
      funct = 6'($urandom);
      if (op == 2'b00 && $urandom_range(0, 3) != 0) funct[4:1] = pick_cmd();
      rd   = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom);
      cond = ($urandom_range(0, 1) == 0) ? 4'hE : 4'($urandom);
      run_instr(op, funct, rd, cond, 4'($urandom), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)), -1, nc, ni, np, nr, nm, nu, ra);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_ldr_waits();
    test_flags_branch();
    test_strne();
    test_reset_midop();
    test_undef();
    test_eors();
    test_random(200);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
